// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: two-stage branch/jump resolver with valid/ready handshake.
// S1 registers the request, S2 registers the resolved direction, mispredict flag
// and redirect PC. Conditional branches train a table of 2-bit saturating
// counters that fetch reads combinationally through LookupPC/LookupTaken.
module branch_resolve_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PHT_DEPTH = 16,
    parameter int unsigned MISS_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    // request side
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        CompCont,
    input  logic [WIDTH-1:0]  RS,
    input  logic [WIDTH-1:0]  RT,
    input  logic [WIDTH-1:0]  PC,
    input  logic [WIDTH-1:0]  Target,
    input  logic              PredTaken,
    input  logic              Flush,
    // fetch-side prediction read
    input  logic [WIDTH-1:0]  LookupPC,
    output logic              LookupTaken,
    // result side
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutTaken,
    output logic              OutMispredict,
    output logic [WIDTH-1:0]  OutRedirectPC,
    output logic [MISS_W-1:0] MissCount
);

    localparam int unsigned IDX_W = $clog2(PHT_DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    typedef enum logic [2:0] {
        CcBgez = 3'b000,
        CcBeq  = 3'b001,
        CcBne  = 3'b010,
        CcBgtz = 3'b011,
        CcBlez = 3'b100,
        CcBltz = 3'b101,
        CcJump = 3'b110,
        CcNop  = 3'b111
    } cond_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    cond_e            s1_cc_q, s1_cc_d;
    logic [WIDTH-1:0] s1_rs_q, s1_rs_d;
    logic [WIDTH-1:0] s1_rt_q, s1_rt_d;
    logic [WIDTH-1:0] s1_pc_q, s1_pc_d;
    logic [WIDTH-1:0] s1_tgt_q, s1_tgt_d;
    logic             s1_pred_q, s1_pred_d;

    logic             out_valid_q, out_valid_d;
    logic             out_taken_q, out_taken_d;
    logic             out_mispred_q, out_mispred_d;
    logic [WIDTH-1:0] out_redirect_q, out_redirect_d;

    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [1:0] pht_q [PHT_DEPTH];
    logic [1:0] pht_d [PHT_DEPTH];

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic s2_free;
    logic advance;
    logic accept;
    logic deliver;

    // S2 can take a new entry when empty or when its current one is consumed.
    assign s2_free = !out_valid_q || OutReady;
    assign advance = s1_valid_q && s2_free && !Flush;
    // Depends only on state, Flush and OutReady; never on InValid.
    assign InReady = !Flush && (!s1_valid_q || s2_free);
    assign accept  = InValid && InReady;
    // A result dropped by Flush does not count as delivered.
    assign deliver = out_valid_q && OutReady && !Flush;

    // ---------------------------------------------------------------------
    // Condition evaluation on the S1 entry
    // ---------------------------------------------------------------------
    logic             rs_neg;
    logic             rs_zero;
    logic             ops_eq;
    logic             s1_taken;
    logic             s1_mispred;
    logic             s1_is_cond;
    logic [WIDTH-1:0] s1_redirect;

    assign rs_neg  = s1_rs_q[WIDTH-1];
    assign rs_zero = (s1_rs_q == '0);
    assign ops_eq  = (s1_rs_q == s1_rt_q);

    // Resolve the branch direction from the registered condition code.
    always_comb begin
        s1_taken = 1'b0;
        unique case (s1_cc_q)
            CcBgez: s1_taken = !rs_neg;
            CcBeq:  s1_taken = ops_eq;
            CcBne:  s1_taken = !ops_eq;
            CcBgtz: s1_taken = !rs_neg && !rs_zero;
            CcBlez: s1_taken = rs_neg || rs_zero;
            CcBltz: s1_taken = rs_neg;
            CcJump: s1_taken = 1'b1;
            CcNop:  s1_taken = 1'b0;
        endcase
    end

    // Only true conditional branches train the predictor; no-ops never mispredict.
    assign s1_is_cond  = (s1_cc_q != CcJump) && (s1_cc_q != CcNop);
    assign s1_mispred  = (s1_cc_q == CcNop) ? 1'b0 : (s1_taken != s1_pred_q);
    assign s1_redirect = s1_taken ? s1_tgt_q : (s1_pc_q + PC_STEP);

    // ---------------------------------------------------------------------
    // Pattern-history table
    // ---------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic [1:0]       upd_ctr;
    logic             unused_lookup_bits;

    assign upd_idx    = s1_pc_q[IDX_W+1:2];
    assign lookup_idx = LookupPC[IDX_W+1:2];
    // Reads the registered table, so a same-cycle update is seen next cycle.
    assign LookupTaken = pht_q[lookup_idx][1];
    assign unused_lookup_bits = ^{LookupPC[WIDTH-1:IDX_W+2], LookupPC[1:0]};

    // Saturating counter update for the branch leaving S1.
    always_comb begin
        pht_d   = pht_q;
        upd_ctr = pht_q[upd_idx];
        if (advance && s1_is_cond) begin
            if (s1_taken) begin
                pht_d[upd_idx] = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
            end else begin
                pht_d[upd_idx] = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
            end
        end
    end

    // Counters reset to weakly not-taken.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else begin
            pht_q <= pht_d;
        end
    end

    // ---------------------------------------------------------------------
    // Stage S1: input register
    // ---------------------------------------------------------------------

    // Load on accept, empty on hand-off to S2, clear on Flush.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cc_d    = s1_cc_q;
        s1_rs_d    = s1_rs_q;
        s1_rt_d    = s1_rt_q;
        s1_pc_d    = s1_pc_q;
        s1_tgt_d   = s1_tgt_q;
        s1_pred_d  = s1_pred_q;
        if (Flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
            s1_cc_d    = cond_e'(CompCont);
            s1_rs_d    = RS;
            s1_rt_d    = RT;
            s1_pc_d    = PC;
            s1_tgt_d   = Target;
            s1_pred_d  = PredTaken;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // S1 registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cc_q    <= CcNop;
            s1_rs_q    <= '0;
            s1_rt_q    <= '0;
            s1_pc_q    <= '0;
            s1_tgt_q   <= '0;
            s1_pred_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cc_q    <= s1_cc_d;
            s1_rs_q    <= s1_rs_d;
            s1_rt_q    <= s1_rt_d;
            s1_pc_q    <= s1_pc_d;
            s1_tgt_q   <= s1_tgt_d;
            s1_pred_q  <= s1_pred_d;
        end
    end

    // ---------------------------------------------------------------------
    // Stage S2: output register and mispredict statistics
    // ---------------------------------------------------------------------

    // Capture the resolved result; data holds while the consumer stalls.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_taken_d    = out_taken_q;
        out_mispred_d  = out_mispred_q;
        out_redirect_d = out_redirect_q;
        if (Flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d    = 1'b1;
            out_taken_d    = s1_taken;
            out_mispred_d  = s1_mispred;
            out_redirect_d = s1_redirect;
        end else if (OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    // Count delivered mispredicts, sticking at all-ones.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (deliver && out_mispred_q && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
        end
    end

    // S2 and statistics registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_q    <= 1'b0;
            out_taken_q    <= 1'b0;
            out_mispred_q  <= 1'b0;
            out_redirect_q <= '0;
            miss_cnt_q     <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_taken_q    <= out_taken_d;
            out_mispred_q  <= out_mispred_d;
            out_redirect_q <= out_redirect_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    assign OutValid      = out_valid_q;
    assign OutTaken      = out_taken_q;
    assign OutMispredict = out_mispred_q;
    assign OutRedirectPC = out_redirect_q;
    assign MissCount     = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (WIDTH=32, PHT_DEPTH=16, MISS_W=4).
module tb_branch_resolve_unit;

    logic        Clk;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic [2:0]  CompCont;
    logic [31:0] RS;
    logic [31:0] RT;
    logic [31:0] PC;
    logic [31:0] Target;
    logic        PredTaken;
    logic        Flush;
    logic [31:0] LookupPC;
    logic        LookupTaken;
    logic        OutValid;
    logic        OutReady;
    logic        OutTaken;
    logic        OutMispredict;
    logic [31:0] OutRedirectPC;
    logic [3:0]  MissCount;

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit #(
        .WIDTH     (32),
        .PHT_DEPTH (16),
        .MISS_W    (4)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .InValid       (InValid),
        .InReady       (InReady),
        .CompCont      (CompCont),
        .RS            (RS),
        .RT            (RT),
        .PC            (PC),
        .Target        (Target),
        .PredTaken     (PredTaken),
        .Flush         (Flush),
        .LookupPC      (LookupPC),
        .LookupTaken   (LookupTaken),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .OutTaken      (OutTaken),
        .OutMispredict (OutMispredict),
        .OutRedirectPC (OutRedirectPC),
        .MissCount     (MissCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] cc, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        CompCont  = cc;
        RS        = rs;
        RT        = rt;
        PC        = pc;
        Target    = tgt;
        PredTaken = pred;
    endtask

    task automatic do_reset();
        Rst_n    = 1'b0;
        InValid  = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b1;
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
    endtask

    // Single request into an empty pipe; checks the result while it is valid.
    task automatic one(input string tag, input logic [2:0] cc, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] pc, input logic pred,
                       input logic exp_t, input logic exp_m, input logic [31:0] exp_r);
        drive(cc, rs, rt, pc, 32'h0000_2000, pred);
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        step();
        check_eq({tag, "_vld"}, OutValid, 1);
        check_eq({tag, "_tkn"}, OutTaken, exp_t);
        check_eq({tag, "_mis"}, OutMispredict, exp_m);
        check_eq({tag, "_rdr"}, OutRedirectPC, exp_r);
        step();
    endtask

    // n back-to-back identical requests, then drain the pipe.
    task automatic issue(input logic [2:0] cc, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc, input logic pred, input int n);
        drive(cc, rs, rt, pc, 32'h0000_2000, pred);
        InValid = 1'b1;
        repeat (n) step();
        InValid = 1'b0;
        step();
        step();
    endtask

    logic [31:0] sweep_rs [5];
    logic [3:0]  sweep_exp [5];
    logic [2:0]  sweep_cc [4];

    initial begin
        logic t;
        // bit j of sweep_exp = expected taken for sweep_cc[j]
        sweep_rs  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
        sweep_exp = '{4'b1100, 4'b1100, 4'b0101, 4'b0011, 4'b0011};
        sweep_cc  = '{3'b000, 3'b011, 3'b100, 3'b101};

        Rst_n    = 1'b0;
        InValid  = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b0;
        LookupPC = 32'h40;
        drive(3'b111, 0, 0, 0, 0, 1'b0);
        #2;
        check_eq("rst_outvalid", OutValid, 0);
        check_eq("rst_taken", OutTaken, 0);
        check_eq("rst_mis", OutMispredict, 0);
        check_eq("rst_redirect", OutRedirectPC, 0);
        check_eq("rst_misscount", MissCount, 0);
        check_eq("rst_lookup", LookupTaken, 0);
        check_eq("rst_inready", InReady, 1);
        @(negedge Clk);
        Rst_n = 1'b1;
        step();

        // Three BEQ taken, predicted not-taken, back to back.
        OutReady = 1'b1;
        drive(3'b001, 5, 5, 32'h40, 32'h100, 1'b0);
        InValid = 1'b1;
        #1;
        check_eq("t1_lookup0", LookupTaken, 0);
        check_eq("t1_inready", InReady, 1);
        step();
        check_eq("t1_lat1_vld", OutValid, 0);
        step();
        check_eq("t1_r1_vld", OutValid, 1);
        check_eq("t1_r1_tkn", OutTaken, 1);
        check_eq("t1_r1_mis", OutMispredict, 1);
        check_eq("t1_r1_rdr", OutRedirectPC, 32'h100);
        check_eq("t1_r1_miss", MissCount, 0);
        step();
        InValid = 1'b0;
        #1;
        check_eq("t1_r2_vld", OutValid, 1);
        check_eq("t1_r2_miss", MissCount, 1);
        check_eq("t1_lookup_trained", LookupTaken, 1);
        step();
        check_eq("t1_r3_vld", OutValid, 1);
        check_eq("t1_r3_mis", OutMispredict, 1);
        step();
        check_eq("t1_drain_vld", OutValid, 0);
        check_eq("t1_miss3", MissCount, 3);

        // Signed condition sweep.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                t = sweep_exp[i][j];
                one($sformatf("sweep_rs%0d_c%0d", i, j), sweep_cc[j], sweep_rs[i],
                    32'h1234_5678, 32'h80, 1'b0, t, t, t ? 32'h2000 : 32'h84);
            end
        end
        one("beq_ne", 3'b001, 3, 4, 32'h80, 1'b0, 1'b0, 1'b0, 32'h84);
        one("bne_ne", 3'b010, 3, 4, 32'h80, 1'b0, 1'b1, 1'b1, 32'h2000);
        one("bne_eq", 3'b010, 7, 7, 32'h80, 1'b0, 1'b0, 1'b0, 32'h84);
        one("beq_sign", 3'b001, 32'h8000_0000, 0, 32'h80, 1'b0, 1'b0, 1'b0, 32'h84);
        one("pc_wrap", 3'b101, 0, 0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'h0);

        // Jump and no-op leave the counter at PC 0x44 alone.
        LookupPC = 32'h44;
        one("jmp", 3'b110, 0, 0, 32'h44, 1'b1, 1'b1, 1'b0, 32'h2000);
        check_eq("jmp_pht", LookupTaken, 0);
        one("beq_44", 3'b001, 9, 9, 32'h44, 1'b1, 1'b1, 1'b0, 32'h2000);
        check_eq("beq_44_pht", LookupTaken, 1);
        one("nop", 3'b111, 0, 0, 32'h44, 1'b1, 1'b0, 1'b0, 32'h48);
        check_eq("nop_pht", LookupTaken, 1);

        // Counter saturation at PC 0x48.
        do_reset();
        LookupPC = 32'h48;
        issue(3'b001, 1, 1, 32'h48, 1'b1, 4);
        issue(3'b001, 1, 2, 32'h48, 1'b0, 1);
        check_eq("pht_sat_hi", LookupTaken, 1);
        issue(3'b001, 1, 2, 32'h48, 1'b0, 4);
        issue(3'b001, 1, 1, 32'h48, 1'b1, 1);
        check_eq("pht_sat_lo", LookupTaken, 0);

        // Backpressure with a continuous request stream.
        do_reset();
        OutReady = 1'b0;
        drive(3'b110, 0, 0, 32'h100, 32'hA00, 1'b1);
        InValid = 1'b1;
        step();
        check_eq("bp_e1_rdy", InReady, 1);
        check_eq("bp_e1_vld", OutValid, 0);
        drive(3'b001, 1, 2, 32'h200, 32'hB00, 1'b0);
        step();
        check_eq("bp_e2_vld", OutValid, 1);
        check_eq("bp_e2_rdr", OutRedirectPC, 32'hA00);
        check_eq("bp_e2_rdy", InReady, 0);
        drive(3'b110, 0, 0, 32'h300, 32'hC00, 1'b1);
        repeat (2) begin
            step();
            check_eq("bp_hold_vld", OutValid, 1);
            check_eq("bp_hold_tkn", OutTaken, 1);
            check_eq("bp_hold_rdr", OutRedirectPC, 32'hA00);
            check_eq("bp_hold_rdy", InReady, 0);
        end
        OutReady = 1'b1;
        InValid  = 1'b0;
        step();
        check_eq("bp_b_vld", OutValid, 1);
        check_eq("bp_b_tkn", OutTaken, 0);
        check_eq("bp_b_mis", OutMispredict, 0);
        check_eq("bp_b_rdr", OutRedirectPC, 32'h204);
        step();
        check_eq("bp_empty", OutValid, 0);
        check_eq("bp_miss", MissCount, 0);

        // Flush with both stages full.
        do_reset();
        LookupPC = 32'h4C;
        OutReady = 1'b0;
        drive(3'b110, 0, 0, 32'h48, 32'hA00, 1'b0);
        InValid = 1'b1;
        step();
        drive(3'b001, 5, 5, 32'h4C, 32'hB00, 1'b0);
        step();
        check_eq("fl_pre_vld", OutValid, 1);
        check_eq("fl_pre_mis", OutMispredict, 1);
        check_eq("fl_pre_rdy", InReady, 0);
        Flush    = 1'b1;
        OutReady = 1'b1;
        drive(3'b110, 0, 0, 32'h300, 32'hC00, 1'b0);
        #1;
        check_eq("fl_rdy_low", InReady, 0);
        step();
        Flush   = 1'b0;
        InValid = 1'b0;
        #1;
        check_eq("fl_post_vld", OutValid, 0);
        check_eq("fl_post_rdy", InReady, 1);
        check_eq("fl_post_miss", MissCount, 0);
        check_eq("fl_post_pht", LookupTaken, 0);
        step();
        check_eq("fl_late_vld", OutValid, 0);
        check_eq("fl_late_miss", MissCount, 0);
        check_eq("fl_late_pht", LookupTaken, 0);

        // Mispredict counter saturation.
        do_reset();
        LookupPC = 32'h50;
        issue(3'b001, 5, 5, 32'h50, 1'b0, 14);
        check_eq("miss14", MissCount, 14);
        issue(3'b001, 5, 5, 32'h50, 1'b0, 6);
        check_eq("miss_sat", MissCount, 15);

        // Asynchronous reset between edges.
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        step();
        check_eq("ar_pre_vld", OutValid, 1);
        check_eq("ar_pre_miss", MissCount, 15);
        check_eq("ar_pre_pht", LookupTaken, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        check_eq("ar_vld", OutValid, 0);
        check_eq("ar_miss", MissCount, 0);
        check_eq("ar_pht", LookupTaken, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined successor to the datapath's combinational branch comparator. It accepts branch/jump resolution requests through a valid/ready handshake and evaluates the branch condition at configurable data width. It trains a pattern-history table of 2-bit saturating counters that the fetch stage reads. It returns the taken decision, a mispredict flag and the redirect PC. It sits between decode/register-read and the fetch PC mux.

## Interface
- WIDTH, 32: data and PC width in bits, ≥ 8.
- PHT_DEPTH, 16: number of pattern-history counters; a power of 2, ≥ 2.
- MISS_W, 16: width of the mispredict statistics counter.
- Clk  in  1  single clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- InValid  in  1  request valid.
- InReady  out  1  unit can accept the request this cycle.
- CompCont  in  3  condition code: 000 BGEZ, 001 BEQ, 010 BNE, 011 BGTZ, 100 BLEZ, 101 BLTZ, 110 unconditional (J/JR/JAL), 111 no-op.
- RS, RT  in  WIDTH  operands, compared as signed.
- PC  in  WIDTH  address of the branch instruction.
- Target  in  WIDTH  taken-path address.
- PredTaken  in  1  prediction fetch made for this branch.
- Flush  in  1  synchronous kill of all in-flight requests.
- LookupPC  in  WIDTH  fetch-side address to predict.
- LookupTaken  out  1  combinational MSB of the counter indexed by LookupPC.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.
- OutTaken  out  1  resolved direction.
- OutMispredict  out  1  OutTaken != captured PredTaken.
- OutRedirectPC  out  WIDTH  Target if taken, else PC+4 (mod 2^WIDTH).
- MissCount  out  MISS_W  saturating count of delivered mispredicts.

## Operation
- PHT index is PC[log2(PHT_DEPTH)+1:2]. LookupPC uses the same index bits.
- Stage S1 is the input register (s1_valid plus all inputs). Stage S2 is the output register (OutValid plus outputs).
- Conditions compare signed RS, and RT where used, against zero:
  - BGEZ: RS ≥ 0.
  - BEQ: RS == RT.
  - BNE: RS != RT.
  - BGTZ: RS > 0.
  - BLEZ: RS ≤ 0.
  - BLTZ: RS < 0.
  - 110: always taken.
  - 111: never taken, and OutMispredict is forced to 0.
- S1→S2 transfer happens when s1_valid && (!OutValid || OutReady) && !Flush. On transfer:
  - S2 captures OutTaken, OutMispredict and OutRedirectPC.
  - For codes 000–101 only, the PHT counter at the S1 PC's index moves +1 (saturating at 11) if taken, or −1 (saturating at 00) if not taken.
  - Codes 110 and 111 never touch the PHT.
- MissCount increments, saturating at all-ones, on each OutValid && OutReady cycle with OutMispredict = 1.
- Flush clears s1_valid and OutValid. A flushed S1 entry makes no PHT update. MissCount is not affected.
- Reset (any time, including mid-operation) clears:
  - s1_valid and OutValid to 0;
  - OutTaken, OutMispredict, OutRedirectPC and MissCount to 0;
  - every PHT counter to 01 (weakly not-taken), so LookupTaken = 0 after reset.

## Timing
- InReady = !Flush && (!s1_valid || (!OutValid || OutReady)). It is combinational, and no combinational path runs from InValid to InReady.
- A request accepted on edge N (InValid && InReady) appears with OutValid = 1 after edge N+1 when the pipe is unstalled. Latency is 2 edges from presentation, 1 edge from S1.
- Throughput is one request per cycle while OutReady = 1.
- OutValid with OutReady = 0 holds every output stable. S1 holds its entry, and InReady drops once S1 is occupied.
- If an S1→S2 PHT write and a LookupPC read hit the same index in the same cycle, LookupTaken returns the pre-update value. The new value is visible the next cycle.
- Back-to-back updates to the same index each apply in order. There is no lost update.
- If Flush and InValid are both high, the request is not accepted (InReady = 0). If Flush and OutReady are both high, the result is dropped and MissCount does not increment.

## Test plan
- Reset, then LookupPC = 0x40 → LookupTaken = 0. Send 3 accepted BEQ at PC = 0x40 with RS = RT = 5 and PredTaken = 0, OutReady = 1:
  - results arrive 2 edges after each request;
  - all show OutTaken = 1, OutMispredict = 1, OutRedirectPC = Target;
  - MissCount = 3, and LookupTaken at 0x40 reads 1 after the second update.
- Condition sweep at WIDTH = 32, RS ∈ {0x80000000, 0xFFFFFFFF, 0, 1, 0x7FFFFFFF}:
  - results match signed semantics for BGEZ/BGTZ/BLEZ/BLTZ;
  - code 110 gives taken; code 111 gives not taken, mispredict 0 and no PHT change;
  - not-taken redirect = PC+4, and PC = 0xFFFFFFFC gives 0x00000000.
- Backpressure: OutReady = 0 for 4 cycles with a continuous InValid stream:
  - InReady = 0 once S1 fills, and outputs stay constant;
  - releasing OutReady delivers both held results in order with no loss.
- Flush while S1 and S2 are both valid, with InValid = 1:
  - next cycle OutValid = 0 and InReady = 1;
  - no PHT change and no MissCount change.
- Assert Rst_n = 0 asynchronously mid-stream between clock edges → OutValid, MissCount and LookupTaken go to 0 immediately, with no clock edge needed.
- Saturation at MISS_W = 4: 20 delivered mispredicts → MissCount = 15. PHT counters saturate at 11 under repeated taken updates and at 00 under repeated not-taken updates.
